video_timing_scaler: RTL and testbench
======================================

# video_timing_scaler

Parameterised raster timing generator with integer pixel replication. It produces sync strobes and an active-video enable for the Pocket video path, plus a source-pixel fetch address issued a configurable number of cycles early, so a VRAM or OLED framebuffer read with fixed latency lands exactly on the active pixel. It sits between the pixel clock domain and the display framebuffer read port. It replaces fixed-geometry, hard-coded timing counters with one block reusable across cores and scales.

## Interface
Parameters:
- SRC_W, 128: source framebuffer width in pixels.
- SRC_H, 64: source framebuffer height in pixels.
- SCALE, 2: integer replication factor, applied to both axes; must be ≥1.
- H_FRONT, 48: horizontal front porch, in clocks.
- H_SYNC, 32: horizontal sync-to-back-porch gap, in clocks.
- H_BACK, 80: horizontal back porch, in clocks.
- V_FRONT, 3: vertical front porch, in lines.
- V_SYNC, 10: vertical sync-to-back-porch gap, in lines.
- V_BACK, 6: vertical back porch, in lines.
- LEAD, 1: number of clocks by which fetch outputs precede video_en; range 0 .. H_BLANK-1.

Ports:
- clk_pixel, in, 1: pixel clock. This is the only clock.
- reset_n, in, 1: asynchronous, active-low reset.
- h_sync, out, 1: one-clock horizontal sync strobe.
- v_sync, out, 1: one-clock vertical sync strobe.
- video_en, out, 1: active-video enable.
- fetch_valid, out, 1: fetch_x and fetch_y are meaningful this clock.
- fetch_x, out, XW = max(1, $clog2(SRC_W)): source column.
- fetch_y, out, YW = max(1, $clog2(SRC_H)): source row.
- frame_start, out, 1: strobe on the first fetch_valid clock of each frame.
- frame_odd, out, 1: toggles once per frame, at frame_start.

## Operation
Derived values:
- H_BLANK = H_FRONT + H_SYNC + H_BACK.
- V_BLANK = V_FRONT + V_SYNC + V_BACK.
- H_ACTIVE = SRC_W × SCALE. This changes under the macro; see Configuration.
- V_ACTIVE = SRC_H × SCALE.
- H_TOTAL = H_BLANK + H_ACTIVE.
- V_TOTAL = V_BLANK + V_ACTIVE.

Counters:
- h_cnt runs 0 .. H_TOTAL-1 and wraps to 0.
- v_cnt increments on the h_cnt wrap. It runs 0 .. V_TOTAL-1 and wraps to 0 on the clock where both counters are at their maximum.

Each line is ordered front porch, sync gap, back porch, then active region. Each frame is ordered the same way, in lines.

Decoded conditions (each drives the corresponding output on the next clock):
- h_sync: h_cnt == H_FRONT.
- v_sync: h_cnt == 0 and v_cnt == V_FRONT.
- video_en: h_cnt ≥ H_BLANK and v_cnt ≥ V_BLANK.
- fetch_valid: h_cnt + LEAD ≥ H_BLANK and h_cnt + LEAD < H_TOTAL and v_cnt ≥ V_BLANK.

Fetch addressing:
- The block contains no divider. Fetch addressing uses a sub-pixel counter 0 .. SCALE-1 and a column counter. Both are preloaded at fetch-window start and advance while in the window.
- fetch_x = (h_cnt + LEAD - H_BLANK) / SCALE.
- A row counter advances every SCALE active lines, giving fetch_y = (v_cnt - V_BLANK) / SCALE.
- fetch_x and fetch_y hold their last value when fetch_valid is low. Consumers ignore them outside fetch_valid.

Frame tracking:
- frame_start pulses with the first fetch_valid of row 0.
- frame_odd flips on the same clock as frame_start.

Reset:
- Asserting reset_n low at any time asynchronously clears all counters and every output to 0.
- A frame in progress is abandoned. No partial-frame completion occurs.

## Timing
- All outputs are registered and lag the internal counter state by one clock.
- After reset release, the first clk_pixel edge evaluates h_cnt = 0, v_cnt = 0.
- Each video_en run is exactly H_ACTIVE clocks long, on each of V_ACTIVE lines per frame.
- The fetch_valid run is the video_en run shifted LEAD clocks earlier, on the same lines. With LEAD = 0 the two runs coincide.
- Each fetch_x value persists for SCALE consecutive clocks. The edge pixels under the macro are the exception; see Configuration.
- A line takes H_TOTAL clocks. A frame takes H_TOTAL × V_TOTAL clocks.
- h_sync and v_sync are each exactly one clock wide. They may coincide only if H_FRONT = 0.

## Configuration
Macro: VIDEO_TIMING_HALF_PIXEL_EN.

Defined:
- H_ACTIVE = (SRC_W - 1) × SCALE.
- fetch_x = (h_cnt + LEAD - H_BLANK + SCALE/2) / SCALE, so pixels 0 and SRC_W-1 each show for SCALE/2 clocks and all other pixels for SCALE.
- SCALE must be even. The block raises an elaboration error if it is odd.

Undefined:
- H_ACTIVE = SRC_W × SCALE.
- Every pixel is SCALE clocks wide.

## Test plan
Common bench parameters: SRC_W=4, SRC_H=2, SCALE=2, H_FRONT=H_SYNC=H_BACK=2, V_FRONT=V_SYNC=V_BACK=1, LEAD=2.

- Reset, then run one frame: H_TOTAL = 14 and V_TOTAL = 7. h_sync fires once per 14 clocks, 3 clocks after each line-start output. v_sync fires once per 98 clocks.
- Active window: video_en high for 8 clocks on each of 4 lines per frame. fetch_valid rises exactly 2 clocks before each video_en rise. fetch_x sequence is 0,0,1,1,2,2,3,3.
- Row mapping: fetch_y reads 0,0,1,1 across the four active lines. frame_start fires once per frame on the first fetch_valid of that frame. frame_odd alternates 1,0,1 over three frames.
- Macro defined: H_ACTIVE = 6 and H_TOTAL = 12. fetch_x sequence is 0,1,1,2,2,3.
- LEAD=0: fetch_valid is identical to video_en on every clock of a frame.
- Mid-line reset: pull reset_n low while video_en is high. All outputs go to 0 immediately without waiting for a clock edge. After release, the first h_sync appears 3 clocks after the first edge.

Source files
------------

// File: rtl/video_timing_scaler.sv
// Raster timing generator with integer pixel replication and early fetch addressing.
// Optional half-pixel edge mode: define VIDEO_TIMING_HALF_PIXEL_EN.
module video_timing_scaler #(
    parameter int SRC_W   = 128,
    parameter int SRC_H   = 64,
    parameter int SCALE   = 2,
    parameter int H_FRONT = 48,
    parameter int H_SYNC  = 32,
    parameter int H_BACK  = 80,
    parameter int V_FRONT = 3,
    parameter int V_SYNC  = 10,
    parameter int V_BACK  = 6,
    parameter int LEAD    = 1,
    localparam int XW     = (SRC_W > 1) ? $clog2(SRC_W) : 1,
    localparam int YW     = (SRC_H > 1) ? $clog2(SRC_H) : 1
) (
    input  logic          clk_pixel,
    input  logic          reset_n,
    output logic          h_sync,
    output logic          v_sync,
    output logic          video_en,
    output logic          fetch_valid,
    output logic [XW-1:0] fetch_x,
    output logic [YW-1:0] fetch_y,
    output logic          frame_start,
    output logic          frame_odd
);

    localparam int H_BLANK  = H_FRONT + H_SYNC + H_BACK;
    localparam int V_BLANK  = V_FRONT + V_SYNC + V_BACK;
`ifdef VIDEO_TIMING_HALF_PIXEL_EN
    localparam int H_ACTIVE = (SRC_W - 1) * SCALE;
    localparam int SUB_INIT = SCALE / 2;
`else
    localparam int H_ACTIVE = SRC_W * SCALE;
    localparam int SUB_INIT = 0;
`endif
    localparam int V_ACTIVE = SRC_H * SCALE;
    localparam int H_TOTAL  = H_BLANK + H_ACTIVE;
    localparam int V_TOTAL  = V_BLANK + V_ACTIVE;
    // h_cnt is wide enough to hold h_cnt + LEAD without overflow
    localparam int HW       = $clog2(H_TOTAL + LEAD + 1);
    localparam int VW       = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
    localparam int SW       = (SCALE > 1) ? $clog2(SCALE) : 1;

    if (SCALE < 1) begin : g_scale_chk
        $error("video_timing_scaler: SCALE must be >= 1");
    end
    if (LEAD < 0 || LEAD > H_BLANK - 1) begin : g_lead_chk
        $error("video_timing_scaler: LEAD must be in 0 .. H_BLANK-1");
    end
`ifdef VIDEO_TIMING_HALF_PIXEL_EN
    if (SCALE % 2 != 0) begin : g_even_chk
        $error("video_timing_scaler: SCALE must be even in half-pixel mode");
    end
`endif

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic [HW-1:0] h_ahead;
    logic          h_wrap;
    logic          v_last;
    logic          v_act;
    logic          fetch_now;
    logic          fetch_first;
    logic [SW-1:0] sub;
    logic [SW-1:0] row_sub;
    logic [YW-1:0] row;

    always_comb begin
        h_ahead     = h_cnt + HW'(LEAD);
        h_wrap      = (h_cnt == HW'(H_TOTAL - 1));
        v_last      = (v_cnt == VW'(V_TOTAL - 1));
        v_act       = (v_cnt >= VW'(V_BLANK));
        fetch_now   = (h_ahead >= HW'(H_BLANK)) && (h_ahead < HW'(H_TOTAL)) && v_act;
        fetch_first = fetch_now && (h_ahead == HW'(H_BLANK));
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_wrap) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    // row/row_sub describe the line v_cnt is on; they stay 0 through vertical blank
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            row     <= '0;
            row_sub <= '0;
        end else if (h_wrap) begin
            if (v_last) begin
                row     <= '0;
                row_sub <= '0;
            end else if (v_act) begin
                if (row_sub == SW'(SCALE - 1)) begin
                    row     <= row + 1'b1;
                    row_sub <= '0;
                end else begin
                    row_sub <= row_sub + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            h_sync      <= 1'b0;
            v_sync      <= 1'b0;
            video_en    <= 1'b0;
            fetch_valid <= 1'b0;
            frame_start <= 1'b0;
            frame_odd   <= 1'b0;
        end else begin
            h_sync      <= (h_cnt == HW'(H_FRONT));
            v_sync      <= (h_cnt == '0) && (v_cnt == VW'(V_FRONT));
            video_en    <= (h_cnt >= HW'(H_BLANK)) && v_act;
            fetch_valid <= fetch_now;
            frame_start <= fetch_first && (v_cnt == VW'(V_BLANK));
            if (fetch_first && (v_cnt == VW'(V_BLANK)))
                frame_odd <= ~frame_odd;
        end
    end

    // Replication without a divider: sub counts clocks within a source pixel.
    // Preloading sub with SCALE/2 shifts every boundary by half a pixel.
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            fetch_x <= '0;
            fetch_y <= '0;
            sub     <= '0;
        end else if (fetch_now) begin
            fetch_y <= row;
            if (fetch_first) begin
                fetch_x <= '0;
                sub     <= SW'(SUB_INIT);
            end else if (sub == SW'(SCALE - 1)) begin
                fetch_x <= fetch_x + 1'b1;
                sub     <= '0;
            end else begin
                sub <= sub + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_video_timing_scaler.sv
// Bench for video_timing_scaler: reference model + scoreboard, fixed-point vector table,
// frame parity, mid-line asynchronous reset. Honours VIDEO_TIMING_HALF_PIXEL_EN.
module tb_video_timing_scaler;

    localparam int SRC_W = 4, SRC_H = 2, SCALE = 2;
    localparam int HF = 2, HS = 2, HBK = 2, VF = 1, VS = 1, VBK = 1, LEAD = 2;
`ifdef VIDEO_TIMING_HALF_PIXEL_EN
    localparam int HACT = (SRC_W - 1) * SCALE, HALF = SCALE / 2;
`else
    localparam int HACT = SRC_W * SCALE, HALF = 0;
`endif
    localparam int HB = HF + HS + HBK, VB = VF + VS + VBK;
    localparam int HT = HB + HACT, VT = VB + SRC_H * SCALE;
    localparam int XW = 2, YW = 1, EW = 6 + XW + YW;

    typedef logic [EW-1:0] vec_t;
    typedef struct {
        int h; int v;
        logic hs; logic vs; logic ve; logic fv; logic fs;
        int fx; int fy;
    } vec_rec_t;

    logic clk = 1'b0, reset_n;
    logic hs, vs, ve, fv, fs, fo;
    logic [XW-1:0] fx;
    logic [YW-1:0] fy;
    logic hs_z, vs_z, ve_z, fv_z, fs_z, fo_z;
    logic [XW-1:0] fx_z;
    logic [YW-1:0] fy_z;

    always #5 clk = ~clk;

    video_timing_scaler #(.SRC_W(SRC_W), .SRC_H(SRC_H), .SCALE(SCALE), .H_FRONT(HF), .H_SYNC(HS),
        .H_BACK(HBK), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VBK), .LEAD(LEAD)) dut (
        .clk_pixel(clk), .reset_n(reset_n), .h_sync(hs), .v_sync(vs), .video_en(ve),
        .fetch_valid(fv), .fetch_x(fx), .fetch_y(fy), .frame_start(fs), .frame_odd(fo));

    video_timing_scaler #(.SRC_W(SRC_W), .SRC_H(SRC_H), .SCALE(SCALE), .H_FRONT(HF), .H_SYNC(HS),
        .H_BACK(HBK), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VBK), .LEAD(0)) dut_z (
        .clk_pixel(clk), .reset_n(reset_n), .h_sync(hs_z), .v_sync(vs_z), .video_en(ve_z),
        .fetch_valid(fv_z), .fetch_x(fx_z), .fetch_y(fy_z), .frame_start(fs_z), .frame_odd(fo_z));

    int tests = 0, fails = 0;
    vec_t sb[$];
    vec_rec_t tab[$];
    logic fo_seen[$];
    int mh, mv, mframe, mfx, mfy, cyc, first_hs, ve_count;
    logic mfo;

    function automatic vec_rec_t rec(int h, int v, logic hs_e, logic vs_e, logic ve_e,
                                     logic fv_e, logic fs_e, int fx_e, int fy_e);
        vec_rec_t r;
        r.h = h; r.v = v; r.hs = hs_e; r.vs = vs_e; r.ve = ve_e; r.fv = fv_e; r.fs = fs_e;
        r.fx = fx_e; r.fy = fy_e;
        return r;
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        mh = 0; mv = 0; mframe = 0; mfx = 0; mfy = 0; mfo = 1'b0; cyc = 0; first_hs = -1;
        sb.delete();
    endtask

    // One clock: push the model's expectation at the edge, compare at the falling edge.
    task automatic step();
        logic e_hs, e_vs, e_ve, e_fv, e_fs;
        int ph, pv, pframe;
        vec_t got, exp;
        @(posedge clk);
        cyc++;
        ph = mh; pv = mv; pframe = mframe;
        e_hs = (mh == HF);
        e_vs = (mh == 0) && (mv == VF);
        e_ve = (mh >= HB) && (mv >= VB);
        e_fv = (mh + LEAD >= HB) && (mh + LEAD < HT) && (mv >= VB);
        e_fs = e_fv && (mh + LEAD == HB) && (mv == VB);
        if (e_fv) begin
            mfx = (mh + LEAD - HB + HALF) / SCALE;
            mfy = (mv - VB) / SCALE;
        end
        if (e_fs) mfo = ~mfo;
        sb.push_back({e_hs, e_vs, e_ve, e_fv, e_fs, mfo, XW'(mfx), YW'(mfy)});
        if (mh == HT - 1) begin
            mh = 0;
            if (mv == VT - 1) begin mv = 0; mframe++; end else mv++;
        end else mh++;
        @(negedge clk);
        got = {hs, vs, ve, fv, fs, fo, fx, fy};
        exp = sb.pop_front();
        check("outputs", 32'(got), 32'(exp));
        check("lead0_fv_ve", {30'd0, fv_z, ve_z}, {30'd0, exp[EW-3], exp[EW-3]});
        if (pframe == 0) begin
            if (ve) ve_count++;
            foreach (tab[i])
                if (tab[i].h == ph && tab[i].v == pv)
                    check($sformatf("vec_h%0d_v%0d", ph, pv),
                          32'({hs, vs, ve, fv, fs, fx, fy}),
                          32'({tab[i].hs, tab[i].vs, tab[i].ve, tab[i].fv, tab[i].fs,
                               XW'(tab[i].fx), YW'(tab[i].fy)}));
        end
        if (hs && first_hs < 0) first_hs = cyc;
        if (fs) fo_seen.push_back(fo);
    endtask

    initial begin
        int n;
        reset_n = 1'b0;
`ifdef VIDEO_TIMING_HALF_PIXEL_EN
        tab.push_back(rec(2, 0, 1, 0, 0, 0, 0, 0, 0));
        tab.push_back(rec(0, 1, 0, 1, 0, 0, 0, 0, 0));
        tab.push_back(rec(4, 3, 0, 0, 0, 1, 1, 0, 0));
        tab.push_back(rec(5, 3, 0, 0, 0, 1, 0, 1, 0));
        tab.push_back(rec(9, 3, 0, 0, 1, 1, 0, 3, 0));
        tab.push_back(rec(10, 3, 0, 0, 1, 0, 0, 3, 0));
        tab.push_back(rec(11, 6, 0, 0, 1, 0, 0, 3, 1));
`else
        tab.push_back(rec(2, 0, 1, 0, 0, 0, 0, 0, 0));
        tab.push_back(rec(0, 1, 0, 1, 0, 0, 0, 0, 0));
        tab.push_back(rec(4, 3, 0, 0, 0, 1, 1, 0, 0));
        tab.push_back(rec(5, 3, 0, 0, 0, 1, 0, 0, 0));
        tab.push_back(rec(6, 3, 0, 0, 1, 1, 0, 1, 0));
        tab.push_back(rec(11, 3, 0, 0, 1, 1, 0, 3, 0));
        tab.push_back(rec(12, 3, 0, 0, 1, 0, 0, 3, 0));
        tab.push_back(rec(13, 4, 0, 0, 1, 0, 0, 3, 0));
        tab.push_back(rec(4, 5, 0, 0, 0, 1, 0, 0, 1));
        tab.push_back(rec(11, 6, 0, 0, 1, 1, 0, 3, 1));
`endif
        model_reset();
        ve_count = 0;
        #12;
        check("reset_state", 32'({hs, vs, ve, fv, fs, fo, fx, fy, hs_z, vs_z, ve_z, fv_z}), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        repeat (3 * HT * VT) step();
        check("first_hsync_edge", 32'(first_hs), 32'd3);
        check("frame0_video_clocks", 32'(ve_count), 32'(HACT * SRC_H * SCALE));
        check("frame_start_count", 32'(fo_seen.size()), 32'd3);
        if (fo_seen.size() >= 3) begin
            check("frame_odd_0", 32'(fo_seen[0]), 32'd1);
            check("frame_odd_1", 32'(fo_seen[1]), 32'd0);
            check("frame_odd_2", 32'(fo_seen[2]), 32'd1);
        end

        // Mid-line asynchronous reset while video is active
        n = 0;
        while (!ve && n < 200) begin step(); n++; end
        check("wait_video_en", 32'(n < 200), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_clear",
              32'({hs, vs, ve, fv, fs, fo, fx, fy, hs_z, vs_z, ve_z, fv_z, fs_z, fo_z}), 32'd0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (HT * VT + HT) step();
        check("first_hsync_after_midreset", 32'(first_hs), 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
